stream_parity: RTL and testbench

Parametrised, pipelined parity generator/checker for a valid/ready data stream. Splits each word into `LANES` lanes of `LANE_W` bits, computes per-lane and whole-word parity over two register stages, and optionally checks against parity bits supplied with the data. It sits inline on datapath buses, upgrading the combinational byte-parity tree to a registered, back-pressurable, width-generic block with error reporting.

---
 rtl/stream_parity_pkg.sv | 27 ++
 rtl/stream_parity_stage.sv | 52 +++++
 rtl/stream_parity.sv | 138 +++++++++++++
 tb/tb_stream_parity.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_parity_pkg.sv
// -----------------------------------------------------------------------------
// stream_parity_pkg
// Shared constants and the lane-parity helper used by stream_parity.
//   DEF_LANES / DEF_LANE_W / DEF_CNT_W : default geometry of the block
//   MAX_LANE_W                          : widest lane the helper accepts
//   lane_par(data, odd)                 : parity bit of one (zero-extended) lane
// -----------------------------------------------------------------------------
package stream_parity_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Lanes narrower than this are zero-extended by the caller; zero bits do
    // not change an XOR reduction, so the result is exact for any LANE_W up
    // to this limit.
    localparam int MAX_LANE_W = 64;

    // Even parity is the XOR of the lane; odd parity is its complement.
    function automatic logic lane_par(input logic [MAX_LANE_W-1:0] data,
                                      input logic                  odd);
        logic xr;
        xr = ^data;
        return odd ? ~xr : xr;
    endfunction

endpackage

// File: rtl/stream_parity_stage.sv
// -----------------------------------------------------------------------------
// parity_stage
// Generic one-entry valid/ready pipeline register (no skid buffer).
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid / in_ready / in_data   : upstream handshake and payload
//   out_valid / out_ready / out_data: downstream handshake and payload
// in_ready is combinational from out_ready so a full stage can accept a new
// word on the same edge its current word leaves.
// -----------------------------------------------------------------------------
module parity_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             load_s;

    assign load_s    = !valid_r || out_ready;
    assign in_ready  = load_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Occupancy flag: on every load the stage takes whatever validity arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r <= in_valid;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Payload is not reset; it only moves with a valid word so it holds while stalled.
    always_ff @(posedge clk) begin
        if (load_s && in_valid) begin
            data_r <= in_data;
        end else begin
            data_r <= data_r;
        end
    end

endmodule

// File: rtl/stream_parity.sv
// -----------------------------------------------------------------------------
// stream_parity
// Two-stage registered parity generator/checker for a valid/ready stream.
// Each word is LANES lanes of LANE_W bits (lane i = in_data[i*LANE_W +: LANE_W]).
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_par : input stream; in_par = expected lane parity
//   out_valid/out_ready/out_data     : output stream; out_data = in_data delayed
//   out_lane_par   : computed lane parity (ODD selects odd parity per lane)
//   out_parity     : XOR of out_lane_par (ODD not applied a second time)
//   out_err        : some lane parity differs from the supplied in_par
//   clr_count      : synchronous clear of err_count (ignored without the counter)
//   err_count      : saturating count of output transfers with out_err set
// Build option: define STREAM_PARITY_ERRCNT_EN to add the err_count port and
// counter; without it clr_count is accepted but has no effect.
// Stage 1 holds {in_par, lane parity, data}; stage 2 holds
// {out_err, word parity, lane parity, data}. in_ready is combinational from
// out_ready through both stages.
// -----------------------------------------------------------------------------
module stream_parity
    import stream_parity_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int ODD    = 0,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*LANE_W-1:0]  in_data,
    input  logic [LANES-1:0]         in_par,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*LANE_W-1:0]  out_data,
    output logic [LANES-1:0]         out_lane_par,
    output logic                     out_parity,
    output logic                     out_err,
    input  logic                     clr_count
`ifdef STREAM_PARITY_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]         err_count
`endif
);

    localparam int   DATA_W = LANES * LANE_W;
    localparam int   S1_W   = DATA_W + 2 * LANES;
    localparam int   S2_W   = DATA_W + LANES + 2;
    localparam logic ODD_B  = (ODD != 32'sd0);

    logic [LANES-1:0] in_lpar_s;
    logic [S1_W-1:0]  s1_in_s;
    logic [S1_W-1:0]  s1_q_s;
    logic             s1_v;
    logic [S2_W-1:0]  s2_in_s;
    logic [S2_W-1:0]  s2_q_s;
    logic             s2_load;
    logic [DATA_W-1:0] s1_data_s;
    logic [LANES-1:0]  s1_lpar_s;
    logic [LANES-1:0]  s1_par_s;
    logic              s1_wpar_s;
    logic              s1_err_s;

    // Per-lane parity of the incoming word (lanes zero-extended for the helper).
    always_comb begin : in_lpar_calc
        logic [MAX_LANE_W-1:0] lane_v;
        in_lpar_s = '0;
        lane_v    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_v                = '0;
            lane_v[LANE_W-1:0]    = in_data[i*LANE_W +: LANE_W];
            in_lpar_s[i]          = lane_par(lane_v, ODD_B);
        end
    end

    assign s1_in_s = {in_par, in_lpar_s, in_data};

    parity_stage #(.WIDTH(S1_W)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_s),
        .out_valid (s1_v),
        .out_ready (s2_load),
        .out_data  (s1_q_s)
    );

    // Word parity and the check against the supplied parity sit between stages.
    assign s1_data_s = s1_q_s[DATA_W-1:0];
    assign s1_lpar_s = s1_q_s[DATA_W +: LANES];
    assign s1_par_s  = s1_q_s[DATA_W+LANES +: LANES];
    assign s1_wpar_s = ^s1_lpar_s;
    assign s1_err_s  = |(s1_lpar_s ^ s1_par_s);
    assign s2_in_s   = {s1_err_s, s1_wpar_s, s1_lpar_s, s1_data_s};

    parity_stage #(.WIDTH(S2_W)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_v),
        .in_ready  (s2_load),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q_s)
    );

    assign out_data     = s2_q_s[DATA_W-1:0];
    assign out_lane_par = s2_q_s[DATA_W +: LANES];
    assign out_parity   = s2_q_s[DATA_W+LANES];
    assign out_err      = s2_q_s[DATA_W+LANES+1];

`ifdef STREAM_PARITY_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating error counter; clear wins over a same-cycle erroneous transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr_count) begin
            cnt_r <= '0;
        end else if (out_valid && out_ready && out_err && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign err_count = cnt_r;
`else
    logic unused_clr_s;
    assign unused_clr_s = clr_count;
`endif

endmodule

// File: tb/tb_stream_parity.sv
// Self-checking bench for stream_parity: three instances share one stimulus
// (even parity, odd parity, and a 2-bit error counter). Expected words are
// queued on input acceptance and compared on each output transfer.
module tb_stream_parity;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  lp0;
        logic        wp0;
        logic        e0;
        logic [3:0]  lp1;
        logic        wp1;
        logic        e1;
        int          ready_at;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  p;
        logic [3:0]  lp0;
        logic        wp0;
        logic        e0;
        logic [3:0]  lp1;
        logic        wp1;
        logic        e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_par;
    logic        out_ready;
    logic        clr_count;

    logic        m_in_ready, m_out_valid, m_out_parity, m_out_err;
    logic [31:0] m_out_data;
    logic [3:0]  m_out_lane_par;
    logic        o_in_ready, o_out_valid, o_out_parity, o_out_err;
    logic [31:0] o_out_data;
    logic [3:0]  o_out_lane_par;
    logic        s_in_ready, s_out_valid, s_out_parity, s_out_err;
    logic [31:0] s_out_data;
    logic [3:0]  s_out_lane_par;
`ifdef STREAM_PARITY_ERRCNT_EN
    logic [15:0] m_err_count;
    logic [15:0] o_err_count;
    logic [1:0]  s_err_count;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    logic mon_en = 1'b0;
    logic bp_en = 1'b0;
    exp_t cur_exp;
    exp_t sb_q[$];
    exp_t pe;
    logic [15:0] exp_cnt = 16'd0;
    logic [15:0] exp_cnt_o = 16'd0;
    logic [1:0]  exp_sat = 2'd0;
    vec_t vec[5];

    stream_parity #(.LANES(4), .LANE_W(8), .ODD(0), .CNT_W(16)) dut_even (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_par(in_par), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_data(m_out_data), .out_lane_par(m_out_lane_par),
        .out_parity(m_out_parity), .out_err(m_out_err), .clr_count(clr_count)
`ifdef STREAM_PARITY_ERRCNT_EN
        , .err_count(m_err_count)
`endif
    );

    stream_parity #(.LANES(4), .LANE_W(8), .ODD(1), .CNT_W(16)) dut_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready),
        .in_data(in_data), .in_par(in_par), .out_valid(o_out_valid),
        .out_ready(out_ready), .out_data(o_out_data), .out_lane_par(o_out_lane_par),
        .out_parity(o_out_parity), .out_err(o_out_err), .clr_count(clr_count)
`ifdef STREAM_PARITY_ERRCNT_EN
        , .err_count(o_err_count)
`endif
    );

    stream_parity #(.LANES(4), .LANE_W(8), .ODD(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_par(in_par), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_lane_par(s_out_lane_par),
        .out_parity(s_out_parity), .out_err(s_out_err), .clr_count(clr_count)
`ifdef STREAM_PARITY_ERRCNT_EN
        , .err_count(s_err_count)
`endif
    );

    always #5 clk = ~clk;

    // edge counter used for latency expectations
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] d, input logic [3:0] p);
        exp_t e;
        e.d = d;
        for (int i = 0; i < 4; i++) begin
            e.lp0[i] = ^d[i*8 +: 8];
            e.lp1[i] = ~e.lp0[i];
        end
        e.wp0 = ^e.lp0;
        e.wp1 = ^e.lp1;
        e.e0  = |(e.lp0 ^ p);
        e.e1  = |(e.lp1 ^ p);
        e.ready_at = 0;
        return e;
    endfunction

    // scoreboard monitor: handshake/timing every cycle, payload on each output transfer
    always @(negedge clk) begin
        int   n;
        logic exp_ov;
        logic ofire;
        exp_t e;
        if (mon_en) begin
            n = sb_q.size();
            exp_ov = 1'b0;
            if (n > 0) exp_ov = (cyc >= sb_q[0].ready_at);
            chk("out_valid", 32'(m_out_valid), 32'(exp_ov));
            chk("odd_out_valid", 32'(o_out_valid), 32'(exp_ov));
            chk("sat_out_valid", 32'(s_out_valid), 32'(exp_ov));
            chk("in_ready", 32'(m_in_ready), 32'((n < 2) || out_ready));
            chk("odd_in_ready", 32'(o_in_ready), 32'((n < 2) || out_ready));
            chk("sat_in_ready", 32'(s_in_ready), 32'((n < 2) || out_ready));
`ifdef STREAM_PARITY_ERRCNT_EN
            chk("err_count", 32'(m_err_count), 32'(exp_cnt));
            chk("odd_err_count", 32'(o_err_count), 32'(exp_cnt_o));
            chk("sat_err_count", 32'(s_err_count), 32'(exp_sat));
`endif
            if (rst) begin
                sb_q.delete();
                exp_cnt = 16'd0; exp_cnt_o = 16'd0; exp_sat = 2'd0;
            end else begin
                ofire = m_out_valid && out_ready;
                pe = '{default: '0};
                if (ofire) begin
                    if (n == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_output: got word 0x%0h, expected none", m_out_data);
                    end else begin
                        pe = sb_q.pop_front();
                        out_cnt++;
                        chk("out_data", m_out_data, pe.d);
                        chk("out_lane_par", 32'(m_out_lane_par), 32'(pe.lp0));
                        chk("out_parity", 32'(m_out_parity), 32'(pe.wp0));
                        chk("out_err", 32'(m_out_err), 32'(pe.e0));
                        chk("odd_out_data", o_out_data, pe.d);
                        chk("odd_lane_par", 32'(o_out_lane_par), 32'(pe.lp1));
                        chk("odd_parity", 32'(o_out_parity), 32'(pe.wp1));
                        chk("odd_err", 32'(o_out_err), 32'(pe.e1));
                        chk("sat_out_data", s_out_data, pe.d);
                        chk("sat_out_err", 32'(s_out_err), 32'(pe.e0));
                    end
                end
                if (clr_count) begin
                    exp_cnt = 16'd0; exp_cnt_o = 16'd0; exp_sat = 2'd0;
                end else if (ofire) begin
                    if (pe.e0 && exp_cnt != 16'hFFFF) exp_cnt++;
                    if (pe.e1 && exp_cnt_o != 16'hFFFF) exp_cnt_o++;
                    if (pe.e0 && exp_sat != 2'd3) exp_sat++;
                end
                if (in_valid && m_in_ready) begin
                    e = cur_exp;
                    e.ready_at = cyc + 2;
                    sb_q.push_back(e);
                end
            end
        end
    end

    // drive one word and hold it until accepted (bounded); optional random out_ready
    task automatic send(input logic [31:0] d, input logic [3:0] p);
        int k;
        in_data = d; in_par = p; in_valid = 1'b1;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (m_in_ready) break;
            @(posedge clk); #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
        if (k == 60) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no acceptance in 60 cycles, expected acceptance of 0x%0h", d);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_model(input logic [31:0] d, input logic [3:0] p);
        cur_exp = mk_exp(d, p);
        send(d, p);
    endtask

    // let the pipeline empty (bounded), then settle one more edge
    task automatic drain();
        int k;
        for (k = 0; k < 80; k++) begin
            @(negedge clk); #1;
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
            out_ready = (k > 40) ? 1'b1 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        if (k == 80) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words left, expected 0", sb_q.size());
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] d;
        logic [3:0]  p;
        //          data           par      lp0      wp0   e0    lp1      wp1   e1
        vec[0] = '{32'h01020304, 4'b1101, 4'b1101, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1};
        vec[1] = '{32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1};
        vec[2] = '{32'hFFFFFFFF, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1};
        vec[3] = '{32'h80FF0001, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1};
        vec[4] = '{32'h7F3E0107, 4'b0000, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_par = 4'd0;
        out_ready = 1'b1; clr_count = 1'b0;
        cur_exp = mk_exp(32'd0, 4'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(m_out_valid), 32'd0);
        chk("reset_in_ready", 32'(m_in_ready), 32'd1);
        @(posedge clk); #1;

        // single word latency: accepted at edge N, visible only after N+1
        cur_exp = '{vec[0].d, vec[0].lp0, vec[0].wp0, vec[0].e0,
                    vec[0].lp1, vec[0].wp1, vec[0].e1, 0};
        send(vec[0].d, vec[0].p);
        @(negedge clk);
        chk("latency_edge_n", 32'(m_out_valid), 32'd0);
        @(negedge clk);
        chk("latency_edge_n1", 32'(m_out_valid), 32'd1);
        @(posedge clk); #1;

        // table vectors, full rate
        for (int i = 0; i < 5; i++) begin
            cur_exp = '{vec[i].d, vec[i].lp0, vec[i].wp0, vec[i].e0,
                        vec[i].lp1, vec[i].wp1, vec[i].e1, 0};
            send(vec[i].d, vec[i].p);
        end
        drain();

        // standalone clear
        @(posedge clk); #1; clr_count = 1'b1;
        @(posedge clk); #1; clr_count = 1'b0;
        @(negedge clk);
`ifdef STREAM_PARITY_ERRCNT_EN
        chk("clear_count", 32'(m_err_count), 32'd0);
`endif
        @(posedge clk); #1;

        // five words with lane 2 parity wrong
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            p = mk_exp(d, 4'd0).lp0 ^ 4'b0100;
            send_model(d, p);
        end
        drain();
`ifdef STREAM_PARITY_ERRCNT_EN
        chk("err_count_5", 32'(m_err_count), 32'd5);
        chk("sat_count_3", 32'(s_err_count), 32'd3);
`endif

        // sixth erroneous word transfers on the same edge as clr_count
        @(posedge clk); #1; out_ready = 1'b0;
        d = 32'hA5A5_0F0F;
        send_model(d, mk_exp(d, 4'd0).lp0 ^ 4'b0100);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_out_valid) break;
        end
        chk("sixth_visible", 32'(m_out_valid), 32'd1);
        @(posedge clk); #1; clr_count = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; clr_count = 1'b0;
        @(negedge clk);
`ifdef STREAM_PARITY_ERRCNT_EN
        chk("clr_priority", 32'(m_err_count), 32'd0);
        chk("clr_priority_sat", 32'(s_err_count), 32'd0);
`endif
        @(posedge clk); #1;

        // back-pressure: 10 words with random out_ready
        k = out_cnt;
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 32'(i);
            send_model(d, mk_exp(d, 4'd0).lp0);
        end
        drain();
        bp_en = 1'b0;
        chk("bp_word_count", 32'(out_cnt - k), 32'd10);
        @(posedge clk); #1;

        // full pipeline, then out_ready rising with input waiting
        out_ready = 1'b0;
        d = 32'h1111_2222; send_model(d, mk_exp(d, 4'd0).lp0 ^ 4'b0001);
        d = 32'h3333_4444; send_model(d, mk_exp(d, 4'd0).lp0);
        d = 32'h5555_6666; cur_exp = mk_exp(d, 4'd0);
        in_data = d; in_par = cur_exp.lp0; in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", 32'(m_in_ready), 32'd0);
        chk("full_out_valid", 32'(m_out_valid), 32'd1);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk("full_release_in_ready", 32'(m_in_ready), 32'd1);
        chk("full_release_out_valid", 32'(m_out_valid), 32'd1);
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("full_again_in_ready", 32'(m_in_ready), 32'd0);
`ifdef STREAM_PARITY_ERRCNT_EN
        chk("pre_reset_count", 32'(m_err_count), 32'd1);
`endif

        // reset while two words are buffered; downstream ready during reset
        @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_out_valid", 32'(m_out_valid), 32'd0);
        chk("mid_reset_in_ready", 32'(m_in_ready), 32'd1);
`ifdef STREAM_PARITY_ERRCNT_EN
        chk("mid_reset_count", 32'(m_err_count), 32'd0);
`endif
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("no_stale_word", 32'(m_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
